async_sram_ctrl: RTL

// Bus-side controller driving the async SRAM PHY's ctrl_* interface.

---
 rtl/async_sram_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/async_sram_ctrl.sv
// async_sram_ctrl: 32-bit valid/ready request port to async SRAM PHY ctrl_*.
// Each request becomes two 16-bit accesses, low halfword first.
//
// Ports:
//   clk, rst_n           clock shared with the PHY, async active-low reset
//   req_valid/req_ready  request handshake, one request in flight
//   req_write            1=write, 0=read
//   req_addr             byte address, bits [1:0] ignored
//   req_wdata/req_wstrb  write data and byte enables
//   resp_valid           one-cycle completion pulse
//   resp_rdata           read data, held until the next read
//   ctrl_addr            halfword address to the PHY (registered there)
//   ctrl_dq_out/_oe      write data and drive enable to the PHY
//   ctrl_dq_in           read data from the PHY pad
//   ctrl_ce_n            tied low
//   ctrl_we_n            to the PHY DDR cell (low pulse in 2nd half-cycle)
//   ctrl_oe_n            output enable to the PHY (registered there)
//   ctrl_byte_n          byte lane enables, [0]=dq[7:0], [1]=dq[15:8]

module async_sram_ctrl #(
    parameter int W_ADDR = 18,
    parameter int W_DATA = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [W_ADDR:0]   req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [W_ADDR-1:0] ctrl_addr,
    output logic [15:0]       ctrl_dq_out,
    output logic [15:0]       ctrl_dq_oe,
    input  logic [15:0]       ctrl_dq_in,
    output logic              ctrl_ce_n,
    output logic              ctrl_we_n,
    output logic              ctrl_oe_n,
    output logic [1:0]        ctrl_byte_n
);

    if (W_DATA != 16) begin : g_bad_width
        $fatal(1, "async_sram_ctrl: W_DATA must be 16");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_A_LO,
        S_D_LO,
        S_A_HI,
        S_D_HI,
        S_RESP
    } state_t;

    state_t            r_state;
    logic              r_write;
    logic [W_ADDR-2:0] r_word;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;

    logic              r_req_ready;
    logic              r_resp_valid;
    logic [31:0]       r_rdata;
    logic [W_ADDR-1:0] r_addr;
    logic [15:0]       r_dq_out;
    logic [15:0]       r_dq_oe;
    logic              r_we_n;
    logic              r_oe_n;
    logic [1:0]        r_byte_n;

    // Request fields used when choosing the next access: straight from
    // the port while idle, otherwise the latched copy.
    logic              w_idle;
    logic              w_ent_write;
    logic [W_ADDR-2:0] w_ent_word;
    logic [3:0]        w_ent_strb;
    logic              w_lo_en;
    logic              w_hi_en;
    logic [1:0]        w_lo_byte_n;
    logic [1:0]        w_hi_byte_n;
    logic              w_unused;

    assign w_idle      = (r_state == S_IDLE);
    assign w_ent_write = w_idle ? req_write : r_write;
    assign w_ent_word  = w_idle ? req_addr[W_ADDR:2] : r_word;
    assign w_ent_strb  = w_idle ? req_wstrb : r_wstrb;

    // A write half with no strobes set is skipped entirely.
    assign w_lo_en = !w_ent_write || (|w_ent_strb[1:0]);
    assign w_hi_en = !w_ent_write || (|w_ent_strb[3:2]);

    assign w_lo_byte_n = w_ent_write ? ~w_ent_strb[1:0] : 2'b00;
    assign w_hi_byte_n = w_ent_write ? ~w_ent_strb[3:2] : 2'b00;

    assign w_unused = ^req_addr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_word       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_addr       <= '0;
            r_dq_out     <= '0;
            r_dq_oe      <= '0;
            r_we_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_byte_n     <= 2'b11;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_word      <= req_addr[W_ADDR:2];
                        r_wdata     <= req_wdata;
                        r_wstrb     <= req_wstrb;
                        r_req_ready <= 1'b0;
                        if (w_lo_en) begin
                            r_state  <= S_A_LO;
                            r_addr   <= {w_ent_word, 1'b0};
                            r_oe_n   <= w_ent_write;
                            r_we_n   <= !w_ent_write;
                            r_byte_n <= w_lo_byte_n;
                        end else if (w_hi_en) begin
                            r_state  <= S_A_HI;
                            r_addr   <= {w_ent_word, 1'b1};
                            r_oe_n   <= w_ent_write;
                            r_we_n   <= !w_ent_write;
                            r_byte_n <= w_hi_byte_n;
                        end else begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                        end
                    end
                end
                S_A_LO: begin
                    r_state  <= S_D_LO;
                    r_we_n   <= 1'b1;
                    r_dq_out <= r_write ? r_wdata[15:0] : 16'h0;
                    r_dq_oe  <= {16{r_write}};
                end
                S_D_LO: begin
                    r_dq_out <= '0;
                    r_dq_oe  <= '0;
                    if (!r_write) begin
                        r_rdata[15:0] <= ctrl_dq_in;
                    end
                    if (w_hi_en) begin
                        r_state  <= S_A_HI;
                        r_addr   <= {w_ent_word, 1'b1};
                        r_oe_n   <= w_ent_write;
                        r_we_n   <= !w_ent_write;
                        r_byte_n <= w_hi_byte_n;
                    end else begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_addr       <= '0;
                        r_oe_n       <= 1'b1;
                        r_byte_n     <= 2'b11;
                    end
                end
                S_A_HI: begin
                    r_state  <= S_D_HI;
                    r_we_n   <= 1'b1;
                    r_dq_out <= r_write ? r_wdata[31:16] : 16'h0;
                    r_dq_oe  <= {16{r_write}};
                end
                S_D_HI: begin
                    r_dq_out <= '0;
                    r_dq_oe  <= '0;
                    if (!r_write) begin
                        r_rdata[31:16] <= ctrl_dq_in;
                    end
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_addr       <= '0;
                    r_oe_n       <= 1'b1;
                    r_byte_n     <= 2'b11;
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_addr       <= '0;
                    r_dq_out     <= '0;
                    r_dq_oe      <= '0;
                    r_we_n       <= 1'b1;
                    r_oe_n       <= 1'b1;
                    r_byte_n     <= 2'b11;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_rdata;
    assign ctrl_addr   = r_addr;
    assign ctrl_dq_out = r_dq_out;
    assign ctrl_dq_oe  = r_dq_oe;
    assign ctrl_ce_n   = 1'b0;
    assign ctrl_we_n   = r_we_n;
    assign ctrl_oe_n   = r_oe_n;
    assign ctrl_byte_n = r_byte_n;

endmodule
